cdc_handshake_tx: RTL and testbench
===================================

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter WIDTH, default 8: width of the transferred data word.
REQ-002 Parameter STAGES, default 2, minimum 2: number of flip-flops in the ack synchronizer chain.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 din  input  WIDTH  word to send to the destination domain.
REQ-006 din_valid  input  1  source offers din this cycle.
REQ-007 din_ready  output  1  block accepts din this cycle.
REQ-008 req_o  output  1  request to destination domain; registered, glitch-free.
REQ-009 data_o  output  WIDTH  registered data bus to destination; stable while a transfer is in flight.
REQ-010 ack_async_i  input  1  acknowledge from destination domain; asynchronous to clk.
REQ-011 done_o  output  1  one-cycle pulse when a transfer has fully completed.
REQ-012 xfer_cnt_o  output  16  count of completed transfers.

Function
REQ-013 ack_async_i SHALL pass through a STAGES-deep flop chain; ack_sync is the last stage; no other logic SHALL sample ack_async_i.
REQ-014 A level sampled on ack_async_i at edge k SHALL be visible on ack_sync after edge k+STAGES-1.
REQ-015 FSM states: IDLE, REQ_HI (req_o=1, wait ack_sync=1), REQ_LO (req_o=0, wait ack_sync=0); 4-phase protocol.
REQ-016 din_ready SHALL be 1 only when state=IDLE and ack_sync=0; combinational from registers only.
REQ-017 Accept = din_valid & din_ready at an edge: data_o<=din, req_o<=1, state<=REQ_HI on that edge.
REQ-018 din_valid while din_ready=0 SHALL be ignored; no data captured, no state change.
REQ-019 In REQ_HI with ack_sync=1: req_o<=0, state<=REQ_LO on that edge.
REQ-020 In REQ_LO with ack_sync=0: state<=IDLE, done_o<=1 for exactly one cycle, xfer_cnt_o<=xfer_cnt_o+1.
REQ-021 xfer_cnt_o SHALL wrap from 0xFFFF to 0x0000 without any flag.
REQ-022 data_o SHALL remain unchanged from accept until the next accept.
REQ-023 ack_sync=1 while IDLE (protocol violation or stale ack) SHALL hold off acceptance and SHALL NOT change state or outputs.
REQ-024 ack_sync falling in REQ_HI before it has risen SHALL have no effect; the FSM stays in REQ_HI.
REQ-025 No timeout: the FSM SHALL wait indefinitely in REQ_HI and REQ_LO.
REQ-026 Minimum transfer period with immediate destination response: 2*STAGES+ destination latency cycles; no back-to-back accepts.

Reset
REQ-027 rstn=0 SHALL asynchronously force: state=IDLE, req_o=0, data_o=0, done_o=0, xfer_cnt_o=0, all synchronizer flops=0.
REQ-028 Reset asserted mid-transfer SHALL abort it; no done_o pulse; xfer_cnt_o=0.
REQ-029 After rstn deasserts, din_ready SHALL be 1 on the first edge once ack_sync=0.

Verification
REQ-030 Basic transfer (STAGES=2): din=0xA5 accepted at edge 0 -> req_o=1, data_o=0xA5 after edge 0; responder model raises ack one cycle after seeing req; done_o=1 for exactly one cycle; xfer_cnt_o=1; data_o still 0xA5 afterward.
REQ-031 Sync latency: ack_async_i rises before edge k in REQ_HI -> req_o falls after edge k+2 (STAGES=2) and after edge k+3 (STAGES=3).
REQ-032 Backpressure: din_valid held high with din changing every cycle during a transfer -> only the word present at the accept edge reaches data_o; din_ready=0 throughout REQ_HI and REQ_LO.
REQ-033 Stale ack: ack_async_i=1 in IDLE with din_valid=1 -> din_ready=0, no accept; ack drops -> accept occurs 2 edges later (STAGES=2).
REQ-034 Reset mid-op: rstn low in REQ_HI -> req_o=0, data_o=0 immediately without a clock edge; no done_o pulse; next transfer completes normally.
REQ-035 Counter wrap: preload 65535 completed transfers (or force) -> next done_o sets xfer_cnt_o=0x0000.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack handshake that carries one data word to another clock domain.
// Latency: req_o rises on the accept edge; ack is seen STAGES edges after it arrives; done_o pulses after the ack falls.
// Backpressure: din_ready is low from accept until the handshake returns to idle with the synchronized ack low.
module cdc_handshake_tx #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             req_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ack_async_i,
    output logic             done_o,
    output logic [15:0]      xfer_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [STAGES-1:0] ack_sync_q;
    logic              ack_sync;
    logic              req_q, req_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              done_q, done_d;
    logic [15:0]       cnt_q, cnt_d;

    // Only the first flop of this chain ever samples the asynchronous ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[STAGES-2:0], ack_async_i};
        end
    end

    assign ack_sync = ack_sync_q[STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // A stale ack left high while idle blocks new work until it has cleared.
    assign din_ready = (state_q == IDLE) && !ack_sync;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (din_valid && din_ready) begin
                    data_d  = din;
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_sync) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_sync) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign req_o      = req_q;
    assign data_o     = data_q;
    assign done_o     = done_q;
    assign xfer_cnt_o = cnt_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: a per-cycle vector table plus hand sequences for
// synchronizer latency, reset abort, responder-driven transfers and counter wrap.
module tb_cdc_handshake_tx;

    logic        clk;
    logic        rstn;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        req_o;
    logic [7:0]  data_o;
    logic        ack;
    logic        done_o;
    logic [15:0] xfer_cnt_o;

    logic [7:0]  din3;
    logic        din_valid3;
    logic        din_ready3;
    logic        req3;
    logic [7:0]  data3;
    logic        ack3;
    logic        done3;
    logic [15:0] cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    cdc_handshake_tx #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .req_o(req_o), .data_o(data_o), .ack_async_i(ack), .done_o(done_o),
        .xfer_cnt_o(xfer_cnt_o)
    );

    cdc_handshake_tx #(.WIDTH(8), .STAGES(3)) dut3 (
        .clk(clk), .rstn(rstn), .din(din3), .din_valid(din_valid3), .din_ready(din_ready3),
        .req_o(req3), .data_o(data3), .ack_async_i(ack3), .done_o(done3),
        .xfer_cnt_o(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [7:0]  din;
        logic        ack;
        logic        rdy;
        logic        req;
        logic [7:0]  dat;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder: echoes req_o onto ack each negedge; counts done pulses over a fixed window.
    task automatic xfer(input logic [7:0] d, output int done_cycles);
        done_cycles = 0;
        @(negedge clk);
        din_valid = 1'b1;
        din = d;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done_o) done_cycles++;
            @(negedge clk);
            din_valid = 1'b0;
            din = ~d;
            ack = req_o;
        end
        ack = 1'b0;
    endtask

    vec_t vt[21];

    initial begin
        int dc;
        int n;
        int seen;

        vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
        vt[1]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
        vt[2]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
        vt[3]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 16'd0};
        vt[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 16'd0};
        vt[5]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 16'd0};
        vt[6]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd1};
        vt[7]  = '{1'b0, 8'h88, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 16'd1};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 16'd1};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 16'd1};
        vt[10] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 16'd1};
        vt[11] = '{1'b1, 8'h5B, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 16'd1};
        vt[12] = '{1'b1, 8'h5C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 16'd1};
        vt[13] = '{1'b1, 8'h5D, 1'b0, 1'b0, 1'b1, 8'h5D, 1'b0, 16'd1};
        vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5D, 1'b0, 16'd1};
        vt[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5D, 1'b0, 16'd1};
        vt[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5D, 1'b0, 16'd1};
        vt[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5D, 1'b0, 16'd1};
        vt[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5D, 1'b0, 16'd1};
        vt[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5D, 1'b1, 16'd2};
        vt[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5D, 1'b0, 16'd2};

        rstn = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        ack = 1'b0;
        din3 = 8'h00;
        din_valid3 = 1'b0;
        ack3 = 1'b0;
        #1;
        check("rst_req", req_o, 1'b0);
        check("rst_data", data_o, 8'h00);
        check("rst_done", done_o, 1'b0);
        check("rst_cnt", xfer_cnt_o, 16'd0);
        check("rst_ready", din_ready, 1'b1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            din_valid = vt[i].vld;
            din = vt[i].din;
            ack = vt[i].ack;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ready", i), din_ready, vt[i].rdy);
            check($sformatf("v%0d_req", i), req_o, vt[i].req);
            check($sformatf("v%0d_data", i), data_o, vt[i].dat);
            check($sformatf("v%0d_done", i), done_o, vt[i].done);
            check($sformatf("v%0d_cnt", i), xfer_cnt_o, vt[i].cnt);
        end

        // STAGES=3 latency: ack set before edge k, req must drop after edge k+3.
        @(negedge clk);
        din_valid3 = 1'b1;
        din3 = 8'hC3;
        @(posedge clk);
        #1;
        check("s3_accept_req", req3, 1'b1);
        check("s3_accept_data", data3, 8'hC3);
        @(negedge clk);
        din_valid3 = 1'b0;
        ack3 = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (!req3) break;
        end
        check("s3_req_fall_edges", n, 4);
        @(negedge clk);
        ack3 = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done3) seen++;
        end
        check("s3_done_pulses", seen, 1);
        check("s3_cnt", cnt3, 16'd1);

        // Reset in REQ_HI clears outputs without a clock edge and produces no done.
        @(negedge clk);
        din_valid = 1'b1;
        din = 8'hE7;
        @(posedge clk);
        #1;
        check("mid_req_hi", req_o, 1'b1);
        check("mid_data", data_o, 8'hE7);
        @(negedge clk);
        din_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_req", req_o, 1'b0);
        check("mid_rst_data", data_o, 8'h00);
        check("mid_rst_cnt", xfer_cnt_o, 16'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (done_o) seen++;
        end
        check("mid_no_done", seen, 0);
        check("mid_ready", din_ready, 1'b1);

        xfer(8'h96, dc);
        check("resp_done_pulses", dc, 1);
        check("resp_cnt", xfer_cnt_o, 16'd1);
        check("resp_data_held", data_o, 8'h96);
        check("resp_ready", din_ready, 1'b1);

        // Counter wrap: preload the count rather than run 65535 transfers.
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        #1;
        check("wrap_preload", xfer_cnt_o, 16'hFFFF);
        xfer(8'h4B, dc);
        check("wrap_done_pulses", dc, 1);
        check("wrap_cnt", xfer_cnt_o, 16'h0000);
        check("wrap_data", data_o, 8'h4B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
